// File: rtl/oled_pkg.sv
// Shared types and opcode constants for the OLED glyph writer.
// Glyph widths are column counts per half-glyph row.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_PG,
        ST_CMD_CL,
        ST_CMD_CH,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [7:0] PAGE_CMD   = 8'hB0;
    localparam logic [7:0] COL_LO_CMD = 8'h00;
    localparam logic [7:0] COL_HI_CMD = 8'h10;

    localparam logic [4:0] W_ASCII = 5'd8;
    localparam logic [4:0] W_CJK   = 5'd16;

endpackage

// File: rtl/oled_glyph_writer.sv
// Streams one 8x16 or 16x16 glyph from the font ROM to the OLED byte
// transmitter: per half-row three page-addressing commands, then W data bytes.
module oled_glyph_writer
    import oled_pkg::*;
#(
    parameter int unsigned ROM_LAT  = 1,
    parameter logic [7:0]  PAGE_CMD = oled_pkg::PAGE_CMD
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] char_code,
    input  logic       char_wide,
    input  logic [2:0] page,
    input  logic [6:0] col,
    output logic [5:0] font_sel,
    output logic       font_row,
    output logic [8:0] index,
    input  logic [7:0] rom_data,
    output logic       tx_valid,
    output logic       tx_dc,
    output logic [7:0] tx_byte,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [5:0] code_q, code_d;
    logic       wide_q, wide_d;
    logic [2:0] page_q, page_d;
    logic [6:0] col_q, col_d;
    logic       row_q, row_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] data_q, data_d;
    logic [5:0] font_sel_q, font_sel_d;
    logic       font_row_q, font_row_d;
    logic [8:0] index_q, index_d;
    logic [3:0] idx_last;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            wide_q     <= 1'b0;
            page_q     <= '0;
            col_q      <= '0;
            row_q      <= 1'b0;
            idx_q      <= '0;
            wait_q     <= '0;
            data_q     <= '0;
            font_sel_q <= '0;
            font_row_q <= 1'b0;
            index_q    <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            wide_q     <= wide_d;
            page_q     <= page_d;
            col_q      <= col_d;
            row_q      <= row_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            data_q     <= data_d;
            font_sel_q <= font_sel_d;
            font_row_q <= font_row_d;
            index_q    <= index_d;
        end
    end

    assign idx_last = wide_q ? 4'(W_CJK - 5'd1) : 4'(W_ASCII - 5'd1);

    // ROM address is loaded on entry to RD_ADDR, so RD_ADDR plus ROM_LAT
    // cycles of RD_WAIT cover the full ROM latency before rom_data is captured.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        wide_d     = wide_q;
        page_d     = page_q;
        col_d      = col_q;
        row_d      = row_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        data_d     = data_q;
        font_sel_d = font_sel_q;
        font_row_d = font_row_q;
        index_d    = index_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    code_d  = char_code;
                    wide_d  = char_wide;
                    page_d  = page;
                    col_d   = col;
                    row_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_CMD_PG;
                end
            end
            ST_CMD_PG: if (tx_ready) state_d = ST_CMD_CL;
            ST_CMD_CL: if (tx_ready) state_d = ST_CMD_CH;
            ST_CMD_CH: begin
                if (tx_ready) begin
                    font_sel_d = code_q;
                    font_row_d = row_q;
                    index_d    = {5'b0, idx_q};
                    state_d    = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                wait_d  = 4'(ROM_LAT - 1);
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_q == '0) begin
                    data_d  = rom_data;
                    state_d = ST_SEND;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q != idx_last) begin
                        idx_d      = idx_q + 4'd1;
                        font_sel_d = code_q;
                        font_row_d = row_q;
                        index_d    = {5'b0, idx_q + 4'd1};
                        state_d    = ST_RD_ADDR;
                    end else if (!row_q) begin
                        row_d   = 1'b1;
                        idx_d   = '0;
                        state_d = ST_CMD_PG;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_byte = '0;
        case (state_q)
            ST_CMD_PG: tx_byte = PAGE_CMD | {5'b0, page_q + {2'b0, row_q}};
            ST_CMD_CL: tx_byte = COL_LO_CMD | {4'h0, col_q[3:0]};
            ST_CMD_CH: tx_byte = COL_HI_CMD | {5'b0, col_q[6:4]};
            ST_SEND:   tx_byte = data_q;
            default:   tx_byte = '0;
        endcase
    end

    assign tx_valid = (state_q == ST_CMD_PG) || (state_q == ST_CMD_CL) ||
                      (state_q == ST_CMD_CH) || (state_q == ST_SEND);
    assign tx_dc    = (state_q == ST_SEND);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign font_sel = font_sel_q;
    assign font_row = font_row_q;
    assign index    = index_q;

endmodule
